// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: shared constants and types for the data-memory stage.
//   - IO page default, timer register offsets, CTRL bit positions
//   - address-decode result enum and the decode helper
package dmem_io_pkg;

    localparam logic [15:0] IO_HI_DEF = 16'hFFFF;

    // Timer register select, taken from memAddr[3:2].
    localparam logic [1:0] CTRL_OFS  = 2'd0;
    localparam logic [1:0] COUNT_OFS = 2'd1;
    localparam logic [1:0] CMP_OFS   = 2'd2;
    localparam logic [1:0] STAT_OFS  = 2'd3;

    // CTRL field positions.
    localparam int EN_B    = 0;
    localparam int IE_B    = 1;
    localparam int AR_B    = 2;
    localparam int PRE_LSB = 8;
    localparam int PRE_MSB = 15;

    // Bits of CTRL that exist; everything else reads back as zero.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    typedef enum logic [1:0] {SEL_RAM, SEL_IO, SEL_NONE} sel_e;

    function automatic sel_e decode_addr(input logic [31:0] addr,
                                         input logic [31:0] ram_bytes,
                                         input logic [15:0] io_hi);
        if (addr < ram_bytes)
            return SEL_RAM;
        else if (addr[31:16] == io_hi && addr[15:4] == 12'd0)
            return SEL_IO;
        else
            return SEL_NONE;
    endfunction

endpackage

// File: rtl/dmem_io_if.sv
// dmem_io_if: core-to-data-memory bus.
//   memAddr/memWriteData/MemRead/MemWrite : core -> memory
//   memReadData (combinational load data), irq (timer interrupt) : memory -> core
interface dmem_io_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] memReadData;
    logic        irq;

    modport master (
        output memAddr, memWriteData, MemRead, MemWrite,
        input  memReadData, irq
    );

    modport slave (
        input  memAddr, memWriteData, MemRead, MemWrite,
        output memReadData, irq
    );
endinterface

// File: rtl/dmem_io_timer.sv
// mmio_timer: memory-mapped programmable timer.
//   clk, reset : clock and synchronous active-high reset
//   rsel       : register select (CTRL, COUNT, COMPARE, STATUS)
//   we         : write strobe, already qualified by the I/O page decode
//   wdata      : store data
//   rdata      : combinational read data of the selected register
//   irq        : PEND & IE, formed only from flops
module mmio_timer
    import dmem_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rsel,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] ctrl;
    logic [31:0] count;
    logic [31:0] compare;
    logic        pend;
    logic [7:0]  psc;

    logic en, ar, tick, hit;
    logic wr_ctrl, wr_count, wr_cmp, wr_stat;

    assign en       = ctrl[EN_B];
    assign ar       = ctrl[AR_B];
    assign tick     = en && (psc == ctrl[PRE_MSB:PRE_LSB]);
    assign hit      = tick && (count == compare);

    assign wr_ctrl  = we && (rsel == CTRL_OFS);
    assign wr_count = we && (rsel == COUNT_OFS);
    assign wr_cmp   = we && (rsel == CMP_OFS);
    assign wr_stat  = we && (rsel == STAT_OFS);

    // NOTE: state uses non-blocking assignments so every register sees
    // the pre-edge values of the others (e.g. hit uses old COUNT/COMPARE).
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl    <= '0;
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            pend    <= 1'b0;
            psc     <= '0;
        end else begin
            if (wr_ctrl)
                ctrl <= wdata & CTRL_MASK;

            if (wr_cmp)
                compare <= wdata;

            if (wr_ctrl || tick)
                psc <= '0;
            else if (en)
                psc <= psc + 8'd1;

            // Software load beats the compare/auto-reload path.
            if (wr_count)
                count <= wdata;
            else if (hit && ar)
                count <= '0;
            else if (tick)
                count <= count + 32'd1;

            // A hit in the same cycle as a W1C clear keeps PEND set.
            if (hit)
                pend <= 1'b1;
            else if (wr_stat && wdata[0])
                pend <= 1'b0;
        end
    end

    assign irq = pend & ctrl[IE_B];

    // NOTE: rdata gets a default before the case so no latch is inferred.
    always_comb begin
        rdata = '0;
        case (rsel)
            CTRL_OFS:  rdata = ctrl;
            COUNT_OFS: rdata = count;
            CMP_OFS:   rdata = compare;
            STAT_OFS:  rdata = {31'd0, pend};
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_io.sv
// dmem_io: data-side memory stage for the single-cycle core.
//   clk, reset : clock and synchronous active-high reset
//   bus        : dmem_io_if.slave (address, store data, strobes in;
//                combinational load data and timer irq out)
// Holds the word RAM, the address decode and the load-data mux; the
// timer lives in mmio_timer on the I/O page.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] IO_HI       = IO_HI_DEF
) (
    input  logic     clk,
    input  logic     reset,
    dmem_io_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] ram [DEPTH_WORDS];
    sel_e        sel;
    logic [AW-1:0] widx;
    logic [31:0] tmr_rdata;
    logic        tmr_irq;
    logic        unused_addr_lsbs;

    assign sel  = decode_addr(bus.memAddr, RAM_BYTES, IO_HI);
    assign widx = bus.memAddr[AW+1:2];

    // Word access only; the byte-lane bits are deliberately dropped.
    assign unused_addr_lsbs = ^bus.memAddr[1:0];

    // NOTE: the RAM array has no reset branch; contents are undefined until
    // written, and stores still land while reset is asserted.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && sel == SEL_RAM)
            ram[widx] <= bus.memWriteData;
    end

    mmio_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .rsel  (bus.memAddr[3:2]),
        .we    (bus.MemWrite && sel == SEL_IO),
        .wdata (bus.memWriteData),
        .rdata (tmr_rdata),
        .irq   (tmr_irq)
    );

    // Reads see pre-edge state, so a read-with-write returns the old value.
    always_comb begin
        bus.memReadData = '0;
        if (bus.MemRead) begin
            case (sel)
                SEL_RAM: bus.memReadData = ram[widx];
                SEL_IO:  bus.memReadData = tmr_rdata;
                default: bus.memReadData = '0;
            endcase
        end
    end

    assign bus.irq = tmr_irq;

endmodule

// File: tb/tb_dmem_io.sv
// tb_dmem_io: directed self-checking bench for dmem_io.
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// so each bus cycle observes the state left by the previous rising edge.
module tb_dmem_io;

    localparam logic [31:0] CTRL_A  = 32'hFFFF_0000;
    localparam logic [31:0] COUNT_A = 32'hFFFF_0004;
    localparam logic [31:0] CMP_A   = 32'hFFFF_0008;
    localparam logic [31:0] STAT_A  = 32'hFFFF_000C;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dmem_io_if bif ();

    dmem_io #(.DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic rs);
        @(negedge clk);
        bif.memAddr      = a;
        bif.memWriteData = wd;
        bif.MemRead      = rd;
        bif.MemWrite     = wr;
        reset            = rs;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(a, d, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        cyc(a, 32'd0, 1'b1, 1'b0, 1'b0);
        check(tag, bif.memReadData, exp);
    endtask

    task automatic idle();
        cyc(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bif.memAddr      = '0;
        bif.memWriteData = '0;
        bif.MemRead      = 1'b0;
        bif.MemWrite     = 1'b0;

        // Reset state.
        cyc(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(32'h10, 32'd0, 1'b0, 1'b0, 1'b1);
        check("rst_irq", {31'd0, bif.irq}, 32'd0);
        check("rst_rdata_idle", bif.memReadData, 32'd0);
        rdchk("rst_ctrl", CTRL_A, 32'd0);
        rdchk("rst_count", COUNT_A, 32'd0);
        rdchk("rst_cmp", CMP_A, 32'hFFFF_FFFF);
        rdchk("rst_stat", STAT_A, 32'd0);

        // RAM access and decode.
        wr(32'h0, 32'h1234_5678);
        wr(32'h10, 32'hDEAD_BEEF);
        rdchk("ram_10", 32'h10, 32'hDEAD_BEEF);
        rdchk("ram_12_lsb_ignored", 32'h12, 32'hDEAD_BEEF);
        rdchk("unmapped_rd", 32'h0040_0000, 32'd0);
        wr(32'h0040_0000, 32'hAAAA_5555);
        rdchk("ram0_after_unmapped_wr", 32'h0, 32'h1234_5678);
        rdchk("io_hole_rd", 32'hFFFF_0010, 32'd0);
        cyc(32'h10, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check("rdata_no_memread", bif.memReadData, 32'd0);
        cyc(32'h10, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
        check("rd_wr_same_cycle_old", bif.memReadData, 32'hDEAD_BEEF);
        rdchk("rd_wr_same_cycle_new", 32'h10, 32'h0000_0001);

        // PRE=0, auto-reload at COMPARE=5 with interrupts enabled.
        wr(CMP_A, 32'd5);
        wr(CTRL_A, 32'h0000_0007);
        for (int i = 0; i <= 6; i++) begin
            rdchk($sformatf("ar_count_%0d", i), COUNT_A, (i <= 5) ? 32'(i) : 32'd0);
            check($sformatf("ar_irq_%0d", i), {31'd0, bif.irq}, (i == 6) ? 32'd1 : 32'd0);
        end
        rdchk("ar_pend", STAT_A, 32'd1);
        wr(STAT_A, 32'd1);
        idle();
        check("irq_after_clear", {31'd0, bif.irq}, 32'd0);
        wr(CTRL_A, 32'd0);

        // PRE=3, COMPARE=2, IE=0: PEND sets 12 edges after the CTRL write.
        wr(STAT_A, 32'd1);
        wr(CMP_A, 32'd2);
        wr(COUNT_A, 32'd0);
        wr(CTRL_A, 32'h0000_0301);
        for (int j = 1; j <= 13; j++)
            rdchk($sformatf("pre3_pend_%0d", j), STAT_A, (j == 13) ? 32'd1 : 32'd0);
        check("pre3_irq_masked", {31'd0, bif.irq}, 32'd0);
        rdchk("pre3_count", COUNT_A, 32'd3);

        // Clear and compare-hit in the same cycle: set wins.
        wr(CTRL_A, 32'd0);
        wr(STAT_A, 32'd1);
        wr(CMP_A, 32'd10);
        wr(COUNT_A, 32'd9);
        wr(CTRL_A, 32'h0000_0001);
        idle();
        wr(STAT_A, 32'd1);
        rdchk("set_wins_over_clear", STAT_A, 32'd1);
        wr(COUNT_A, 32'd100);
        rdchk("count_load_priority", COUNT_A, 32'd100);

        // No auto-reload: wrap at 32'hFFFFFFFF, single PEND.
        wr(CTRL_A, 32'd0);
        wr(STAT_A, 32'd1);
        wr(CMP_A, 32'hFFFF_FFFF);
        wr(COUNT_A, 32'hFFFF_FFFE);
        wr(CTRL_A, 32'h0000_0001);
        rdchk("wrap_fffe", COUNT_A, 32'hFFFF_FFFE);
        rdchk("wrap_ffff", COUNT_A, 32'hFFFF_FFFF);
        rdchk("wrap_zero", COUNT_A, 32'd0);
        rdchk("wrap_pend", STAT_A, 32'd1);
        wr(STAT_A, 32'd0);
        rdchk("stat_w0_keeps", STAT_A, 32'd1);
        wr(STAT_A, 32'd1);
        rdchk("wrap_pend_cleared", STAT_A, 32'd0);
        rdchk("wrap_pend_once", STAT_A, 32'd0);

        // Reset mid-operation with irq asserted.
        wr(CTRL_A, 32'd0);
        wr(CMP_A, 32'd7);
        wr(COUNT_A, 32'd7);
        wr(CTRL_A, 32'h0000_0003);
        idle();
        idle();
        check("irq_before_reset", {31'd0, bif.irq}, 32'd1);
        cyc(COUNT_A, 32'd55, 1'b0, 1'b1, 1'b1);
        cyc(32'h20, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
        rdchk("mid_rst_ctrl", CTRL_A, 32'd0);
        check("mid_rst_irq", {31'd0, bif.irq}, 32'd0);
        rdchk("mid_rst_count", COUNT_A, 32'd0);
        rdchk("mid_rst_cmp", CMP_A, 32'hFFFF_FFFF);
        rdchk("mid_rst_stat", STAT_A, 32'd0);
        rdchk("ram_wr_during_reset", 32'h20, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
